// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the native memory request slice.
// Timeout logic in the slice is built only when MEM_TIMEOUT_EN is defined.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEF_ERR_DATA       = 32'hDEADBEEF;

    // Wide enough for the largest legal TIMEOUT_CYCLES (65535).
    localparam int unsigned TMO_CNT_W          = 16;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating count of cycles spent waiting in REQ; expire_o marks the last allowed wait cycle.
// Instantiated by mem_req_slice only when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr
    import mem_bus_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);
    localparam logic [TMO_CNT_W-1:0] SAT  = '1;

    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of REQ cycles already completed, so the
    // LIMIT-th REQ cycle sees cnt_q == LIMIT-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/mem_req_slice.sv
// Register slice between a CPU native memory port and the interconnect, with optional
// bus timeout (define MEM_TIMEOUT_EN); without it REQ waits forever and err_* are tied 0.
module mem_req_slice
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s_mem_valid,
    output logic        s_mem_ready,
    input  logic [31:0] s_mem_addr,
    input  logic [31:0] s_mem_wdata,
    input  logic [3:0]  s_mem_wstrb,
    output logic [31:0] s_mem_rdata,

    output logic        m_mem_valid,
    input  logic        m_mem_ready,
    output logic [31:0] m_mem_addr,
    output logic [31:0] m_mem_wdata,
    output logic [3:0]  m_mem_wstrb,
    input  logic [31:0] m_mem_rdata,

    output logic        err_pulse,
    output logic [31:0] err_addr
);

    mem_state_e  state_q;
    mem_req_t    req_q;
    logic        m_valid_q;
    logic        s_ready_q;
    logic [31:0] rdata_q;
    logic        accept;

    assign accept = (state_q == ST_IDLE) && s_mem_valid;

`ifdef MEM_TIMEOUT_EN
    logic        tmo_expire;
    logic        err_pulse_q;
    logic [31:0] err_addr_q;

    mem_timeout_ctr #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (accept),
        .en_i     (state_q == ST_REQ),
        .expire_o (tmo_expire)
    );

    assign err_pulse = err_pulse_q;
    assign err_addr  = err_addr_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{ERR_DATA, TIMEOUT_CYCLES};
    assign err_pulse  = 1'b0;
    assign err_addr   = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            m_valid_q   <= 1'b0;
            s_ready_q   <= 1'b0;
            rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
            err_pulse_q <= 1'b0;
            err_addr_q  <= '0;
`endif
        end else begin
            s_ready_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_pulse_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (s_mem_valid) begin
                        req_q     <= '{addr: s_mem_addr, wdata: s_mem_wdata, wstrb: s_mem_wstrb};
                        m_valid_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A slave answer in the expiry cycle still counts as a good response.
                    if (m_mem_ready) begin
                        rdata_q   <= m_mem_rdata;
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_expire) begin
                        rdata_q     <= ERR_DATA;
                        m_valid_q   <= 1'b0;
                        s_ready_q   <= 1'b1;
                        err_pulse_q <= 1'b1;
                        err_addr_q  <= req_q.addr;
                        state_q     <= ST_RESP;
                    end
`endif
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_mem_valid = m_valid_q;
    assign m_mem_addr  = req_q.addr;
    assign m_mem_wdata = req_q.wdata;
    assign m_mem_wstrb = req_q.wstrb;
    assign s_mem_ready = s_ready_q;
    assign s_mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_req_slice.sv
// Self-checking bench for mem_req_slice: vector table, scoreboard monitor, slave model
// and a reset-abort sequence; timeout vectors are used when MEM_TIMEOUT_EN is defined.
module tb_mem_req_slice;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_mem_valid;
    logic        s_mem_ready;
    logic [31:0] s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [3:0]  s_mem_wstrb;
    logic [31:0] s_mem_rdata;
    logic        m_mem_valid;
    logic        m_mem_ready;
    logic [31:0] m_mem_addr;
    logic [31:0] m_mem_wdata;
    logic [3:0]  m_mem_wstrb;
    logic [31:0] m_mem_rdata;
    logic        err_pulse;
    logic [31:0] err_addr;

    mem_req_slice #(
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (32'hDEADBEEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_mem_valid (s_mem_valid),
        .s_mem_ready (s_mem_ready),
        .s_mem_addr  (s_mem_addr),
        .s_mem_wdata (s_mem_wdata),
        .s_mem_wstrb (s_mem_wstrb),
        .s_mem_rdata (s_mem_rdata),
        .m_mem_valid (m_mem_valid),
        .m_mem_ready (m_mem_ready),
        .m_mem_addr  (m_mem_addr),
        .m_mem_wdata (m_mem_wdata),
        .m_mem_wstrb (m_mem_wstrb),
        .m_mem_rdata (m_mem_rdata),
        .err_pulse   (err_pulse),
        .err_addr    (err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          delay;      // valid cycles before slave ready, -1 = silent
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;        // cycles from s_mem_valid to s_mem_ready
        bit          scramble;   // disturb s_mem_* payload while busy
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] addr;
        int          lat;
        int          t_issue;
    } exp_t;

    int          chk = 0;
    int          errs = 0;
    int          cyc = 0;
    int          n_err = 0;
    int          slv_delay = -1;
    int          slv_cnt = 0;
    logic [31:0] slv_rdata = '0;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    logic [3:0]  cur_wstrb = '0;
    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: answers after slv_delay valid cycles and checks payload stability.
    always @(negedge clk) begin
        m_mem_ready = 1'b0;
        m_mem_rdata = 32'h0BAD0BAD;
        if (rst || !m_mem_valid) begin
            slv_cnt = 0;
        end else begin
            check("m_addr_stable", m_mem_addr, cur_addr);
            check("m_wdata_stable", m_mem_wdata, cur_wdata);
            check("m_wstrb_stable", 32'(m_mem_wstrb), 32'(cur_wstrb));
            if (slv_delay >= 0 && slv_cnt == slv_delay) begin
                m_mem_ready = 1'b1;
                m_mem_rdata = slv_rdata;
            end
            slv_cnt++;
        end
    end

    // Response monitor: pops the scoreboard on every s_mem_ready pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_mem_ready) begin
                if (sb.size() == 0) begin
                    chk++;
                    errs++;
                    $display("FAIL unexpected_resp: got s_mem_ready with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_rdata", s_mem_rdata, mon_e.rdata);
                    check("resp_err", 32'(err_pulse), 32'(mon_e.err));
                    check("resp_latency", 32'(cyc - mon_e.t_issue), 32'(mon_e.lat));
                    check("resp_m_valid_low", 32'(m_mem_valid), 32'd0);
`ifdef MEM_TIMEOUT_EN
                    if (mon_e.err) check("err_addr", err_addr, mon_e.addr);
`else
                    check("err_addr_tied", err_addr, 32'd0);
`endif
                end
            end
            if (err_pulse) begin
                n_err++;
                if (!s_mem_ready) begin
                    chk++;
                    errs++;
                    $display("FAIL err_pulse_alone: got err_pulse=1 expected 0 outside response (cycle %0d)", cyc);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        cur_addr    = a;
        cur_wdata   = wd;
        cur_wstrb   = ws;
        s_mem_valid = 1'b1;
        s_mem_addr  = a;
        s_mem_wdata = wd;
        s_mem_wstrb = ws;
    endtask

    task automatic push_exp(input logic [31:0] rd, input logic er, input logic [31:0] a, input int lat);
        exp_t e;
        e = '{rdata: rd, err: er, addr: a, lat: lat, t_issue: cyc};
        sb.push_back(e);
    endtask

    task automatic wait_resp(input string name, input bit scr, input logic [31:0] hold_rdata);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (scr && k == 0) begin
                s_mem_addr  = ~cur_addr;
                s_mem_wdata = ~cur_wdata;
                s_mem_wstrb = ~cur_wstrb;
            end
            if (s_mem_ready) begin
                got = 1'b1;
                break;
            end
        end
        s_mem_valid = 1'b0;
        check({name, "_resp_seen"}, 32'(got), 32'd1);
        @(negedge clk);
        check({name, "_ready_one_cycle"}, 32'(s_mem_ready), 32'd0);
        check({name, "_rdata_hold"}, s_mem_rdata, hold_rdata);
    endtask

    initial begin
        #5_000_000;
        errs++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

    initial begin
        int exp_nerr;
        vecs.push_back('{32'h10000004, 32'h00000000, 4'h0, 0, 32'h12345678, 32'h12345678, 1'b0, 2, 1'b0});
        vecs.push_back('{32'h20000000, 32'hA5A5A5A5, 4'hF, 5, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 7, 1'b0});
        vecs.push_back('{32'h30000008, 32'h00000000, 4'h0, 1, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 3, 1'b1});
        vecs.push_back('{32'h4000000C, 32'h000000EE, 4'h1, 2, 32'h11111111, 32'h11111111, 1'b0, 4, 1'b0});
        vecs.push_back('{32'h00000000, 32'h00000000, 4'h0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2, 1'b0});
`ifdef MEM_TIMEOUT_EN
        vecs.push_back('{32'h50000000, 32'h00000000, 4'h0, -1, 32'h00000000, 32'hDEADBEEF, 1'b1, 9, 1'b0});
        vecs.push_back('{32'h60000000, 32'h00000000, 4'h0, 7, 32'h77777777, 32'h77777777, 1'b0, 9, 1'b0});
        vecs.push_back('{32'h61000000, 32'h00000000, 4'h0, 6, 32'h66666666, 32'h66666666, 1'b0, 8, 1'b0});
        exp_nerr = 1;
`else
        vecs.push_back('{32'h70000000, 32'h00000000, 4'h0, 1000, 32'h13572468, 32'h13572468, 1'b0, 1002, 1'b0});
        exp_nerr = 0;
`endif

        rst         = 1'b1;
        s_mem_valid = 1'b0;
        s_mem_addr  = '0;
        s_mem_wdata = '0;
        s_mem_wstrb = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_m_valid", 32'(m_mem_valid), 32'd0);
        check("rst_s_ready", 32'(s_mem_ready), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_s_rdata", s_mem_rdata, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_m_addr", m_mem_addr, 32'd0);
        check("rst_m_wstrb", 32'(m_mem_wstrb), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            slv_delay = vecs[i].delay;
            slv_rdata = vecs[i].rdata;
            issue(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            push_exp(vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].addr, vecs[i].lat);
            wait_resp($sformatf("vec%0d", i), vecs[i].scramble, vecs[i].exp_rdata);
        end

        // Reset two cycles into REQ: transaction is dropped, held request re-issued.
        slv_delay = -1;
        issue(32'h80000000, 32'h00000000, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check("abort_m_valid_before", 32'(m_mem_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_m_valid_async", 32'(m_mem_valid), 32'd0);
        check("abort_s_ready_async", 32'(s_mem_ready), 32'd0);
        check("abort_m_addr_async", m_mem_addr, 32'd0);
        @(negedge clk);
        check("abort_m_valid_held", 32'(m_mem_valid), 32'd0);
        check("abort_s_rdata_clr", s_mem_rdata, 32'd0);
        slv_delay = 0;
        slv_rdata = 32'h24681357;
        rst = 1'b0;
        push_exp(32'h24681357, 1'b0, 32'h80000000, 2);
        wait_resp("reissue", 1'b0, 32'h24681357);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("err_pulse_count", 32'(n_err), 32'(exp_nerr));
        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule

// File: doc/mem_req_slice.md
MEM_REQ_SLICE -- requirements
Module: mem_req_slice

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: TIMEOUT_CYCLES, default 255, cycles waited for m_mem_ready before an error response (1..65535).
REQ-003 Parameter: ERR_DATA, default 32'hDEADBEEF, read data returned on timeout.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  asynchronous active-high reset.
REQ-006 Ports: s_mem_valid in 1, s_mem_ready out 1, s_mem_addr in 32, s_mem_wdata in 32, s_mem_wstrb in 4, s_mem_rdata out 32; CPU-side native memory port.
REQ-007 Ports: m_mem_valid out 1, m_mem_ready in 1, m_mem_addr out 32, m_mem_wdata out 32, m_mem_wstrb out 4, m_mem_rdata in 32; interconnect-side port, same protocol.
REQ-008 Port: err_pulse  out  1  one-cycle strobe on bus timeout.
REQ-009 Port: err_addr  out  32  address of the most recent timed-out request.

Function
REQ-010 Protocol: the requester holds valid and payload until ready; ready is a one-cycle pulse carrying rdata; wstrb==0 is a read.
REQ-011 The FSM SHALL have states IDLE, REQ and RESP.
REQ-012 IDLE: when s_mem_valid=1, register addr/wdata/wstrb, go to REQ; m_mem_valid=1 from the next cycle.
REQ-013 REQ: m_mem_valid=1 and m_mem_addr/wdata/wstrb come from registers, stable until m_mem_ready; the timeout counter increments each cycle.
REQ-014 REQ with m_mem_ready=1: capture m_mem_rdata, clear m_mem_valid next cycle, go to RESP.
REQ-015 RESP: s_mem_ready=1 for exactly one cycle with s_mem_rdata = captured data, then go to IDLE.
REQ-016 Outside RESP, s_mem_ready SHALL be 0 and s_mem_rdata SHALL hold its last value.
REQ-017 Latency: s_mem_valid at cycle t0 with slave ready at first m_mem_valid gives m_mem_valid at t0+1 and s_mem_ready at t0+2; otherwise s_mem_ready comes one cycle after m_mem_ready.
REQ-018 A new request SHALL be accepted only in IDLE; back-to-back throughput is one transaction per 3 cycles minimum.
REQ-019 Timeout: if the counter reaches TIMEOUT_CYCLES in REQ without m_mem_ready, drop m_mem_valid, load ERR_DATA as response data, pulse err_pulse, load err_addr, go to RESP.
REQ-020 If m_mem_ready and timeout occur in the same cycle, ready wins: normal data, no error.
REQ-021 The counter SHALL clear on entry to REQ and SHALL never wrap.
REQ-022 Payload changes on s_mem_* while not in IDLE SHALL be ignored.

Reset
REQ-023 rst SHALL force, immediately and asynchronously: state=IDLE, m_mem_valid=0, s_mem_ready=0, err_pulse=0, all data/address registers=0, counter=0.
REQ-024 rst mid-transaction SHALL abandon the transaction with no response; after rst releases, a still-high s_mem_valid is accepted as new.

Configuration
REQ-025 Macro MEM_TIMEOUT_EN defined: counter, err_pulse and err_addr behave as in REQ-019..021.
REQ-026 MEM_TIMEOUT_EN undefined: no counter, REQ waits indefinitely, err_pulse tied 0, err_addr tied 0, ports still present.

Structure
REQ-027 Package mem_bus_pkg SHALL hold the FSM state encoding, the default ERR_DATA and the default TIMEOUT_CYCLES constants.
REQ-028 Sub-module mem_timeout_ctr (clear, enable, expire output) SHALL be instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-029 Read of 0x10000004, slave ready at first m_mem_valid with rdata=0x12345678 -> s_mem_ready at t0+2, s_mem_rdata=0x12345678, err_pulse never set.
REQ-030 Write 0x20000000 wdata=0xA5A5A5A5 wstrb=4'hF, slave ready after 5 cycles -> m_mem_* payload stable all 5 cycles, single s_mem_ready pulse.
REQ-031 TIMEOUT_CYCLES=8, read 0x50000000 with no slave ready -> m_mem_valid drops after 8 REQ cycles, s_mem_rdata=0xDEADBEEF, err_pulse one cycle, err_addr=0x50000000.
REQ-032 TIMEOUT_CYCLES=8, m_mem_ready on the 8th REQ cycle -> slave data returned, err_pulse=0.
REQ-033 rst pulsed in REQ 2 cycles after issue -> m_mem_valid=0 same cycle, no s_mem_ready; a held s_mem_valid is re-issued after release.
REQ-034 Build without MEM_TIMEOUT_EN, slave silent for 1000 cycles, then ready -> m_mem_valid high throughout, normal response, err_pulse=0.
